// File: rtl/i2s_pkg.sv
// Shared types and encodings for the I2S ADC receive path.
//   state_e      : capture FSM states
//   CHSEL_*      : chan_sel encodings (bit 1 set means both channels)
//   CHAN_*       : record_chan / word channel values (follows LRCK level)
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAITL = 2'd1,
    SHIFT = 2'd2,
    WAITE = 2'd3
  } state_e;

  localparam logic [1:0] CHSEL_LEFT  = 2'b00;
  localparam logic [1:0] CHSEL_RIGHT = 2'b01;
  localparam logic [1:0] CHSEL_BOTH  = 2'b10;

  localparam logic CHAN_LEFT  = 1'b0;
  localparam logic CHAN_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// Synchronises the three codec lines into the clk domain and derives the
// bit-rate events used by the capture FSM.
//   clk, rst_n  : system clock, async active-low reset
//   bclk_i      : codec bit clock (sampled as data)
//   lrck_i      : codec frame clock
//   dat_i       : codec serial data
//   bit_tick_o  : one-clk pulse per BCLK rising edge
//   lrck_o      : synchronised LRCK, aligned with bit_tick_o
//   lr_edge_o   : bit_tick_o where LRCK changed since the previous tick
//   dat_o       : synchronised data, aligned with bit_tick_o
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bclk_i,
  input  logic lrck_i,
  input  logic dat_i,
  output logic bit_tick_o,
  output logic lrck_o,
  output logic lr_edge_o,
  output logic dat_o
);

  // Same depth on every line so BCLK, LRCK and DAT stay mutually aligned.
  logic [SYNC_STAGES-1:0] bclk_sr_q, lrck_sr_q, dat_sr_q;
  logic bclk_prev_q, lrck_lat_q;
  logic tick_q, lrck_q, edge_q, dat_q;

  logic bclk_s, lrck_s, dat_s, rise_d;
  assign bclk_s = bclk_sr_q[SYNC_STAGES-1];
  assign lrck_s = lrck_sr_q[SYNC_STAGES-1];
  assign dat_s  = dat_sr_q[SYNC_STAGES-1];
  assign rise_d = bclk_s & ~bclk_prev_q;

  // Event outputs are registered together so tick, LRCK and DAT seen by the
  // FSM always belong to the same BCLK edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sr_q   <= '0;
      lrck_sr_q   <= '0;
      dat_sr_q    <= '0;
      bclk_prev_q <= 1'b0;
      lrck_lat_q  <= 1'b0;
      tick_q      <= 1'b0;
      lrck_q      <= 1'b0;
      edge_q      <= 1'b0;
      dat_q       <= 1'b0;
    end else begin
      bclk_sr_q   <= {bclk_sr_q[SYNC_STAGES-2:0], bclk_i};
      lrck_sr_q   <= {lrck_sr_q[SYNC_STAGES-2:0], lrck_i};
      dat_sr_q    <= {dat_sr_q[SYNC_STAGES-2:0], dat_i};
      bclk_prev_q <= bclk_s;
      tick_q      <= rise_d;
      lrck_q      <= lrck_s;
      dat_q       <= dat_s;
      edge_q      <= rise_d & (lrck_s != lrck_lat_q);
      if (rise_d) lrck_lat_q <= lrck_s;
    end
  end

  assign bit_tick_o = tick_q;
  assign lrck_o     = lrck_q;
  assign lr_edge_o  = edge_q;
  assign dat_o      = dat_q;

endmodule

// File: rtl/i2s_adc_rx.sv
// WM8731 ADC serial capture: I2S or left-justified, DATA_W-bit samples,
// per-channel selection, valid/ready output with sticky overrun.
//   clk, rst_n                     : system clock, async active-low reset
//   AUD_BCLK/AUD_ADCLRCK/AUD_ADCDAT: codec serial interface (sampled)
//   start                          : capture enable (level)
//   chan_sel                       : 00 left, 01 right, 1x both
//   record_data/record_chan        : captured sample and its channel
//   record_valid/record_ready      : output handshake
//   overrun/clr_overrun            : sticky dropped-sample flag and clear
module i2s_adc_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int I2S_DELAY   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              AUD_BCLK,
  input  logic              AUD_ADCLRCK,
  input  logic              AUD_ADCDAT,
  input  logic              start,
  input  logic [1:0]        chan_sel,
  output logic [DATA_W-1:0] record_data,
  output logic              record_chan,
  output logic              record_valid,
  input  logic              record_ready,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam int CW = $clog2(DATA_W + 1);

  logic bit_tick, lrck_s, lr_edge, dat_s;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .bclk_i    (AUD_BCLK),
    .lrck_i    (AUD_ADCLRCK),
    .dat_i     (AUD_ADCDAT),
    .bit_tick_o(bit_tick),
    .lrck_o    (lrck_s),
    .lr_edge_o (lr_edge),
    .dat_o     (dat_s)
  );

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] sh_q;
  logic              chan_q;   // channel of the word being shifted
  logic [DATA_W-1:0] data_q;
  logic              rchan_q, valid_q, ovr_q;

  logic [DATA_W-1:0] shift_d, open_sh_d;
  logic [CW-1:0]     open_cnt_d;
  logic              open_word, word_done, chan_en, load, drop;

  assign shift_d = {sh_q[DATA_W-2:0], dat_s};

  // I2S: the LRCK-edge bit is the previous word's LSB, so it is skipped.
  // Left-justified: that same bit is already our MSB.
  assign open_sh_d  = (I2S_DELAY != 0) ? '0 : DATA_W'(dat_s);
  assign open_cnt_d = (I2S_DELAY != 0) ? '0 : CW'(1);

  // WAITL only opens on a left word so stereo pairs stay aligned; in SHIFT
  // an edge before DATA_W bits silently discards the partial word.
  assign open_word = lr_edge && ((state_q == SHIFT) || (state_q == WAITE) ||
                                 ((state_q == WAITL) && (lrck_s == CHAN_LEFT)));

  assign word_done = start && (state_q == SHIFT) && bit_tick && !lr_edge &&
                     (cnt_q == CW'(DATA_W - 1));

  assign chan_en = ((chan_sel & CHSEL_BOTH) != 2'b00) ||
                   ((chan_sel == CHSEL_LEFT)  && (chan_q == CHAN_LEFT)) ||
                   ((chan_sel == CHSEL_RIGHT) && (chan_q == CHAN_RIGHT));

  assign load = word_done && chan_en && (!valid_q || record_ready);
  assign drop = word_done && chan_en && valid_q && !record_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      chan_q  <= CHAN_LEFT;
      data_q  <= '0;
      rchan_q <= CHAN_LEFT;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // Output register: a coinciding load keeps valid high with new data.
      if (load) begin
        data_q  <= shift_d;
        rchan_q <= chan_q;
        valid_q <= 1'b1;
      end else if (valid_q && record_ready) begin
        valid_q <= 1'b0;
      end

      if (drop)             ovr_q <= 1'b1;
      else if (clr_overrun) ovr_q <= 1'b0;

      if (!start) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        sh_q    <= '0;
      end else if (state_q == IDLE) begin
        state_q <= WAITL;
      end else if (open_word) begin
        state_q <= SHIFT;
        chan_q  <= lrck_s;
        cnt_q   <= open_cnt_d;
        sh_q    <= open_sh_d;
      end else if ((state_q == SHIFT) && bit_tick) begin
        cnt_q <= cnt_q + CW'(1);
        sh_q  <= shift_d;
        if (word_done) state_q <= WAITE;
      end
    end
  end

  assign record_data  = data_q;
  assign record_chan  = rchan_q;
  assign record_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
module tb_i2s_adc_rx;

  localparam int SS = 2;   // synchroniser depth of both instances
  localparam int HB = 4;   // clks per BCLK half period

  logic clk = 1'b0, rst_n = 1'b0;
  logic bclk = 1'b0, lrck = 1'b0, dat = 1'b0;
  logic start16 = 1'b0, start24 = 1'b0, rdy16 = 1'b1, rdy24 = 1'b1;
  logic clr16 = 1'b0, clr24 = 1'b0;
  logic [1:0] cs16 = 2'b10, cs24 = 2'b10;
  logic [15:0] d16;
  logic [23:0] d24;
  logic c16, v16, o16, c24, v24, o24;

  always #5 clk = ~clk;

  i2s_adc_rx #(.DATA_W(16), .SYNC_STAGES(SS), .I2S_DELAY(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck),
    .AUD_ADCDAT(dat), .start(start16), .chan_sel(cs16),
    .record_data(d16), .record_chan(c16), .record_valid(v16),
    .record_ready(rdy16), .overrun(o16), .clr_overrun(clr16));

  i2s_adc_rx #(.DATA_W(24), .SYNC_STAGES(SS), .I2S_DELAY(0)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck),
    .AUD_ADCDAT(dat), .start(start24), .chan_sel(cs24),
    .record_data(d24), .record_chan(c24), .record_valid(v24),
    .record_ready(rdy24), .overrun(o24), .clr_overrun(clr24));

  typedef struct {logic [31:0] data; logic chan;} exp_t;
  typedef struct {logic [1:0] cs; logic lr; logic [15:0] data; logic expd;} vec_t;

  exp_t q16[$], q24[$];
  exp_t e16, e24;
  vec_t vecs[11];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, lsb_cyc = 0;
  int raise_at = -1, rst_at = -1, rel_at = -1;
  logic v16_p = 1'b0, hs16_p = 1'b0, v24_p = 1'b0, hs24_p = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Codec model: LRCK/DAT change while BCLK is low, receiver samples on rise.
  // Bits outside the data word are driven high so a stray capture shows up.
  task automatic send_slot(input logic lr, input logic [31:0] data, input int w,
                           input int slot, input int dly);
    int idx;
    for (int b = 0; b < slot; b++) begin
      idx  = b - dly;
      lrck = lr;
      dat  = (idx >= 0 && idx < w) ? data[w-1-idx] : 1'b1;
      if (b == raise_at) start16 = 1'b1;
      if (b == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(v16), 32'd0);
        chk("rst_data", 32'(d16), 32'd0);
        chk("rst_chan", 32'(c16), 32'd0);
        chk("rst_ovr", 32'(o16), 32'd0);
      end
      if (b == rel_at) rst_n = 1'b1;
      tick(HB);
      bclk = 1'b1;
      if (idx == w - 1) lsb_cyc = cyc;
      tick(HB);
      bclk = 1'b0;
    end
  endtask

  task automatic send16(input logic lr, input logic [15:0] data);
    send_slot(lr, 32'(data), 16, 18, 1);
  endtask

  task automatic send24(input logic lr, input logic [23:0] data, input int slot);
    send_slot(lr, 32'(data), 24, slot, 0);
  endtask

  // Scoreboard / latency monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (v16 && (!v16_p || hs16_p)) chk("lat16", 32'(cyc - lsb_cyc), 32'(SS + 2));
      if (v16 && rdy16) begin
        if (q16.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL out16: unexpected sample 0x%0h chan %0d", d16, c16);
        end else begin
          e16 = q16.pop_front();
          chk("data16", 32'(d16), e16.data);
          chk("chan16", 32'(c16), 32'(e16.chan));
        end
      end
      if (v24 && (!v24_p || hs24_p)) chk("lat24", 32'(cyc - lsb_cyc), 32'(SS + 2));
      if (v24 && rdy24) begin
        if (q24.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL out24: unexpected sample 0x%0h chan %0d", d24, c24);
        end else begin
          e24 = q24.pop_front();
          chk("data24", 32'(d24), e24.data);
          chk("chan24", 32'(c24), 32'(e24.chan));
        end
      end
    end
    v16_p = v16; hs16_p = v16 && rdy16;
    v24_p = v24; hs24_p = v24 && rdy24;
  end

  initial begin
    // both channels, then right-only, then left-only
    vecs[0]  = '{2'b10, 1'b1, 16'hDEAD, 1'b0};  // still waiting for a left edge
    vecs[1]  = '{2'b10, 1'b0, 16'hA5C3, 1'b1};
    vecs[2]  = '{2'b10, 1'b1, 16'h1234, 1'b1};
    vecs[3]  = '{2'b01, 1'b0, 16'h7777, 1'b0};
    vecs[4]  = '{2'b01, 1'b1, 16'h0001, 1'b1};
    vecs[5]  = '{2'b01, 1'b0, 16'h5555, 1'b0};
    vecs[6]  = '{2'b01, 1'b1, 16'h0002, 1'b1};
    vecs[7]  = '{2'b01, 1'b0, 16'h6666, 1'b0};
    vecs[8]  = '{2'b01, 1'b1, 16'h0003, 1'b1};
    vecs[9]  = '{2'b00, 1'b0, 16'h8001, 1'b1};
    vecs[10] = '{2'b00, 1'b1, 16'h4242, 1'b0};

    tick(3);
    chk("init_valid16", 32'(v16), 32'd0);
    chk("init_data16", 32'(d16), 32'd0);
    chk("init_chan16", 32'(c16), 32'd0);
    chk("init_ovr16", 32'(o16), 32'd0);
    chk("init_valid24", 32'(v24), 32'd0);
    rst_n = 1'b1;
    start16 = 1'b1;
    tick(2);

    for (int i = 0; i < 11; i++) begin
      cs16 = vecs[i].cs;
      if (vecs[i].expd) q16.push_back('{32'(vecs[i].data), vecs[i].lr});
      send16(vecs[i].lr, vecs[i].data);
    end

    // start raised in the middle of a right word: first output must be left
    start16 = 1'b0;
    send16(1'b0, 16'h1357);
    raise_at = 5;
    send16(1'b1, 16'h2468);
    raise_at = -1;
    cs16 = 2'b11;
    q16.push_back('{32'h0000BEEF, 1'b0});
    send16(1'b0, 16'hBEEF);
    q16.push_back('{32'h0000CAFE, 1'b1});
    send16(1'b1, 16'hCAFE);

    // back-pressure: second left sample dropped, first one held
    cs16 = 2'b00;
    rdy16 = 1'b0;
    q16.push_back('{32'h00001111, 1'b0});
    send16(1'b0, 16'h1111);
    send16(1'b1, 16'h9999);
    send16(1'b0, 16'h2222);
    send16(1'b1, 16'h9999);
    chk("ovr_held_data", 32'(d16), 32'h1111);
    chk("ovr_held_valid", 32'(v16), 32'd1);
    chk("ovr_set", 32'(o16), 32'd1);
    clr16 = 1'b1;
    tick(1);
    clr16 = 1'b0;
    chk("ovr_cleared", 32'(o16), 32'd0);
    rdy16 = 1'b1;
    tick(2);
    chk("ovr_drained", 32'(v16), 32'd0);
    chk("ovr_stays_clr", 32'(o16), 32'd0);

    // 24-bit left-justified, 32-bit slots, then a short slot
    start16 = 1'b0;
    start24 = 1'b1;
    send24(1'b1, 24'h0F0F0F, 32);
    q24.push_back('{32'h00800001, 1'b0});
    send24(1'b0, 24'h800001, 32);
    q24.push_back('{32'h00123456, 1'b1});
    send24(1'b1, 24'h123456, 32);
    send24(1'b0, 24'hFFFFFF, 10);
    q24.push_back('{32'h0000ABCD, 1'b1});
    send24(1'b1, 24'h00ABCD, 32);
    q24.push_back('{32'h007FFFFE, 1'b0});
    send24(1'b0, 24'h7FFFFE, 32);
    chk("ovr24", 32'(o24), 32'd0);
    start24 = 1'b0;

    // reset while shifting with a sample pending
    start16 = 1'b1;
    cs16 = 2'b10;
    rdy16 = 1'b0;
    send16(1'b1, 16'h5A5A);
    send16(1'b0, 16'h0F0F);
    chk("pend_valid", 32'(v16), 32'd1);
    rst_at = 8;
    rel_at = 10;
    send16(1'b1, 16'h7E7E);
    rst_at = -1;
    rel_at = -1;
    rdy16 = 1'b1;
    q16.push_back('{32'h00003C3C, 1'b0});
    send16(1'b0, 16'h3C3C);
    q16.push_back('{32'h0000C3C3, 1'b1});
    send16(1'b1, 16'hC3C3);
    tick(10);

    chk("q16_empty", 32'(q16.size()), 32'd0);
    chk("q24_empty", 32'(q24.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_adc_rx.md
Name: i2s_adc_rx

Overview:
Parametrised I2S/left-justified serial capture block for the WM8731 ADC path. It replaces the fixed 16-bit left-only ADC receiver. It runs on the system clock, synchronises BCLK/ADCLRCK/ADCDAT, and deserialises DATA_W-bit samples for the selected channel(s). Samples go to the recorder through a valid/ready handshake, with sticky overrun reporting.

Parameters:
DATA_W, 16, sample width in bits (legal 8..32)
SYNC_STAGES, 2, synchroniser depth applied identically to all three codec inputs (legal >=2)
I2S_DELAY, 1, 1 = Philips I2S (MSB one BCLK after LRCK edge), 0 = left-justified (MSB on first BCLK after LRCK edge)

Ports:
clk  in  1  system clock, must be >= 4x BCLK frequency
rst_n  in  1  asynchronous reset, active low
AUD_BCLK  in  1  codec bit clock; sampled, not used as a clock
AUD_ADCLRCK  in  1  codec frame clock; low = left, high = right
AUD_ADCDAT  in  1  codec serial data, MSB first
start  in  1  level enable for capture
chan_sel  in  2  00 left only, 01 right only, 1x both
record_data  out  DATA_W  captured sample
record_chan  out  1  0 left, 1 right; qualifies record_data
record_valid  out  1  sample pending
record_ready  in  1  consumer accepts when valid&ready
overrun  out  1  sticky: a completed sample was dropped
clr_overrun  in  1  synchronous clear of overrun

Behaviour:
- Reset: record_data=0, record_chan=0, record_valid=0, overrun=0, state=IDLE, counter=0, shift register=0.
- All three codec inputs pass through SYNC_STAGES flops, so they stay mutually aligned.
- bit_tick = synced BCLK rising edge (synced=1, previous=0). It is one clk wide.
- lr_edge = bit_tick while synced LRCK differs from the LRCK value latched at the previous bit_tick.
- Channel of a word = synced LRCK level at the lr_edge that opens it.
- States:
  - IDLE: start=0. Go to WAITL when start=1.
  - WAITL: wait for lr_edge with new LRCK=0, so capture always begins on a left word and stereo pairs stay aligned. On that edge, enter SHIFT.
  - SHIFT: on each bit_tick, shift ADCDAT into the LSB and increment counter.
    - I2S_DELAY=1: the bit_tick that is the lr_edge is skipped, counter=0.
    - I2S_DELAY=0: that bit_tick captures the MSB, counter=1.
    - When counter reaches DATA_W, raise the word-complete strobe and go to WAITE.
  - WAITE: ignore extra bit_ticks (codec slot wider than DATA_W). On any lr_edge, open a new word for the new channel as in SHIFT entry.
- Short slot: an lr_edge in SHIFT before DATA_W bits discards the partial word. No output and no overrun. Open the new word immediately.
- start=0 in any state: go to IDLE next clk and discard the partial word. A pending output stays until handshake.
- Word complete, with the channel enabled by chan_sel:
  - If record_valid=0, or record_ready=1 in the same cycle: load record_data/record_chan and set record_valid=1 on the next clk.
  - Otherwise drop the new sample, keep the pending one, set overrun=1.
- Word complete with the channel disabled: discard silently.
- Handshake: record_valid clears on the clk after valid&ready, unless a new load coincides (then it stays 1 with new data). record_data/record_chan hold stable while valid=1 and ready=0.
- Latency: record_valid asserts 1 clk after the clk containing the LSB bit_tick. That is SYNC_STAGES+2 clks after the BCLK pin rising edge.
- overrun: set has priority over clr_overrun in the same cycle.
- Counter width $clog2(DATA_W+1). No arithmetic on data (raw two's complement passed through).

Decomposition:
- Package i2s_pkg:
  - state enum {IDLE, WAITL, SHIFT, WAITE}
  - chan_sel encodings CHSEL_LEFT/CHSEL_RIGHT/CHSEL_BOTH
  - CHAN_LEFT=0, CHAN_RIGHT=1
- Sub-module i2s_sync_edge: SYNC_STAGES synchroniser for BCLK/LRCK/DAT, producing bit_tick, synced lrck, lr_edge and synced dat.
- The FSM, shifter and output register stay in i2s_adc_rx.

Test Plan:
- I2S_DELAY=1, DATA_W=16, chan_sel=both, ready=1, codec sends L=0xA5C3, R=0x1234 -> two pulses: (0xA5C3, chan 0) then (0x1234, chan 1), each SYNC_STAGES+2 clks after LSB BCLK rise.
- start raised while LRCK high, mid right word -> no output until next falling LRCK; first output is the left sample.
- chan_sel=01, three stereo frames with right words 0x0001, 0x0002, 0x0003 -> exactly three outputs with those values, record_chan=1, no left outputs.
- ready=0 across two left samples 0x1111, 0x2222 (chan_sel=00) -> record_data holds 0x1111, overrun=1; clr_overrun pulse -> overrun=0; ready=1 -> 0x1111 accepted.
- DATA_W=24, I2S_DELAY=0, 32-bit codec slots, L=0x800001 -> output 0x800001, trailing 8 bits ignored. Short 10-bit slot -> no output, next word captured correctly.
- rst_n asserted mid-SHIFT with valid=1 -> all outputs 0 immediately. After release with start=1, the next full left word is captured correctly.
